// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the instruction sequencer.
//   - opcode constants for the seven defined instructions
//   - FSM state encoding (exported on the sequencer debug port)
//   - instruction field bit positions
//   - small decode helpers used by the sequencer
package seq_pkg;

  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0011;
  localparam logic [3:0] OP_STORE = 4'b0100;
  localparam logic [3:0] OP_EQUAL = 4'b0101;
  localparam logic [3:0] OP_ADD   = 4'b1001;
  localparam logic [3:0] OP_SUB   = 4'b1010;

  // Instruction word: [15:12] opcode, [11] A/B select, [10:8] unused, [7:0] operand address
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int SEL_BIT  = 11;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXECUTE = 3'd2,
    LOAD_WB = 3'd3,
    HALT    = 3'd4
  } state_t;

  // ALU instructions always write their result to B.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_OR) || (op == OP_AND) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Instructions that keep the program running (everything else halts).
  function automatic logic is_running_op(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction-ROM and data-memory bus of the sequencer.
//   rom_address/rom_data : 12-bit instruction address, 16-bit combinational ROM word
//   mem_addr             : 8-bit data-memory byte address
//   mem_rd_en/mem_rdata  : read strobe; mem_rdata is valid on the cycle after the strobe
//   mem_wr_en/mem_wdata  : write strobe; the write commits on the clock edge ending the strobe cycle
// Bus semantics: there is no valid/ready back-pressure. The memories are always ready;
// a strobe high for one cycle is exactly one transfer, and mem_rd_en/mem_wr_en are
// never high together. master = sequencer, slave = memories.
interface instr_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [11:0]       rom_address;
  logic [15:0]       rom_data;
  logic [7:0]        mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output rom_address, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    input  rom_data, mem_rdata
  );

  modport slave (
    input  rom_address, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
    output rom_data, mem_rdata
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: combinational ALU for the sequencer.
//   a, b    : operands (A and B registers)
//   opcode  : instruction opcode
//   result  : value written to B for ALU opcodes, 0 otherwise
//   carry   : carry out of ADD, borrow of SUB (a < b), 0 otherwise
module seq_alu
  import seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_OR:  result = a | b;
      OP_AND: result = a & b;
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute controller.
//   clk, reset (async, active-high), start (level, sampled in IDLE only)
//   bus        : instruction ROM and data-memory bus (master side)
//   reg_a/reg_b: architectural registers
//   carry      : carry of ADD / borrow of SUB, held by all other instructions
//   equal      : result of EQUAL
//   done       : high while in HALT
//   invalid_op : HALT caused by an undefined opcode
//   state_dbg  : current FSM state
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  instr_sequencer_if.master bus,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              carry,
  output logic              equal,
  output logic              done,
  output logic              invalid_op,
  output state_t            state_dbg
);

  state_t            state, next_state;
  logic [11:0]       pc;
  logic [15:0]       ir;
  logic [3:0]        opcode;
  logic              sel_b;
  logic [DATA_W-1:0] sel_reg;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  assign opcode  = ir[OPC_MSB:OPC_LSB];
  assign sel_b   = ir[SEL_BIT];
  assign sel_reg = sel_b ? reg_b : reg_a;

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (reg_a),
    .b      (reg_b),
    .opcode (opcode),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and memory strobes. Strobes are decoded from the registered state,
  // so an asynchronous reset drops a pending write in the same cycle.
  always_comb begin
    next_state    = state;
    bus.mem_addr  = '0;
    bus.mem_rd_en = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_wdata = '0;
    case (state)
      IDLE:    if (start) next_state = FETCH;
      FETCH:   next_state = EXECUTE;
      EXECUTE: begin
        bus.mem_addr = ir[ADDR_MSB:ADDR_LSB];
        if (opcode == OP_LOAD) begin
          bus.mem_rd_en = 1'b1;
          next_state    = LOAD_WB;
        end else if (opcode == OP_STORE) begin
          bus.mem_wr_en = 1'b1;
          bus.mem_wdata = sel_reg;
          next_state    = FETCH;
        end else if (is_alu_op(opcode)) begin
          next_state = FETCH;
        end else begin
          next_state = HALT;
        end
      end
      LOAD_WB: next_state = FETCH;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      ir         <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      carry      <= 1'b0;
      equal      <= 1'b0;
      invalid_op <= 1'b0;
    end else begin
      case (state)
        FETCH: ir <= bus.rom_data;
        EXECUTE: begin
          if (is_alu_op(opcode)) reg_b <= alu_result;
          if (opcode == OP_ADD || opcode == OP_SUB) carry <= alu_carry;
          if (opcode == OP_EQUAL) equal <= (reg_a == reg_b);
          if (!is_running_op(opcode) && opcode != OP_EQUAL) invalid_op <= 1'b1;
          // Halting instructions leave PC pointing at themselves; 12-bit wrap is natural.
          if (is_running_op(opcode)) pc <= pc + 12'd1;
        end
        LOAD_WB: begin
          if (sel_b) reg_b <= bus.mem_rdata;
          else       reg_a <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_address = pc;
  assign done            = (state == HALT);
  assign state_dbg       = state;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Fetch/decode/execute controller that drives the 12-bit instruction ROM address and consumes the 16-bit instruction word it returns. It holds the accumulator registers A and B and performs LOAD/STORE against the byte-addressed data memory. It executes the ALU operations and halts on EQUAL or on an invalid opcode. It sits between the instruction ROM and the data memory, at the top of the Tarea3 datapath.

## Interface
Parameters:
- DATA_W, 8, width of registers A, B and of the data-memory words.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  level; leaves IDLE and begins fetching at PC=0.
- rom_address  out  12  instruction address, equal to PC.
- rom_data  in  16  instruction word, combinational from the ROM.
  - Format: [15:12] opcode, [11] A/B select, [10:8] unused, [7:0] operand address.
- mem_addr  out  8  data-memory address.
- mem_rd_en  out  1  read strobe; mem_rdata is valid on the following cycle.
- mem_rdata  in  DATA_W  read data.
- mem_wr_en  out  1  write strobe; the write commits on the same edge.
- mem_wdata  out  DATA_W  write data.
- reg_a, reg_b  out  DATA_W  architectural registers.
- carry  out  1  carry out of ADD; borrow of SUB (set when A<B).
- equal  out  1  result of EQUAL.
- done  out  1  high in HALT.
- invalid_op  out  1  HALT was caused by an undefined opcode.

## Operation
- Opcodes:
  - 0001 OR: B←A|B.
  - 0010 AND: B←A&B.
  - 0011 LOAD: sel?B:A ← mem[op_addr].
  - 0100 STORE: mem[op_addr] ← sel?B:A.
  - 0101 EQUAL: equal←(A==B), then halt.
  - 1001 ADD: B←A+B.
  - 1010 SUB: B←A−B.
  - Every other opcode, including 0000: invalid_op←1, halt.
- ALU results always write B. A/B select matters only for LOAD and STORE.
- Arithmetic is modulo 2^DATA_W.
  - carry is updated only by ADD and SUB; all other instructions hold it.
- FSM states: IDLE, FETCH, EXECUTE, LOAD_WB, HALT.
  - IDLE: outputs quiescent. Goes to FETCH when start=1.
  - FETCH: rom_address=PC; latch rom_data into IR.
  - EXECUTE: decode IR.
    - ALU ops update B.
    - STORE asserts mem_wr_en.
    - LOAD asserts mem_rd_en and goes to LOAD_WB.
    - EQUAL and invalid opcodes go to HALT.
    - PC←PC+1, except on the halting instructions.
    - Non-halting ops other than LOAD return to FETCH.
  - LOAD_WB: write mem_rdata into the selected register; go to FETCH.
  - HALT: done=1; stays until reset. start is ignored.
- PC wraps 4095→0 with no flag.
- mem_addr=IR[7:0] while in EXECUTE; 0 otherwise.
- mem_wdata is the selected register during STORE; 0 otherwise.
- At most one of mem_rd_en and mem_wr_en is high in any cycle.

## Timing
- Reset values: state IDLE, PC 0, IR 0, and every output 0 (rom_address, mem_*, reg_a, reg_b, carry, equal, done, invalid_op).
- Cycles per instruction:
  - ALU op and STORE: 2 (FETCH, EXECUTE).
  - LOAD: 3 (FETCH, EXECUTE, LOAD_WB).
  - EQUAL and invalid: 2, then HALT.
- Register results are visible on the outputs the cycle after EXECUTE (after LOAD_WB for LOAD).
- done and equal/invalid_op rise on the same edge that enters HALT.
- Reset asserted mid-instruction:
  - Any pending write is dropped; state, PC and outputs clear at once.
  - After release the block waits in IDLE for start.
- start is sampled only in IDLE. Holding it high has no further effect.
- Back-to-back LOAD then ALU op: the ALU uses the value written in LOAD_WB; no bypass is needed.

## Structure
- Shared package seq_pkg:
  - Opcode constants OP_OR, OP_AND, OP_LOAD, OP_STORE, OP_EQUAL, OP_ADD, OP_SUB.
  - State encoding.
  - Instruction field bit positions.
- One sub-module, seq_alu: combinational; inputs A, B and opcode; outputs result and carry.
- The FSM, PC, IR and register file stay in instr_sequencer.

## Test plan
- mem[0]=3, mem[1]=5; program LOAD A 0, LOAD B 1, ADD, STORE B 15 -> mem[15]=8, reg_b=8, carry=0, PC=4 after 10 cycles.
- mem[2]=6, mem[3]=6; program LOAD A 2, LOAD B 3, SUB, STORE B 16, then OR and AND with A=3, B=5 -> mem[16]=0, reg_b=7 after OR, and B=3&7=3 after AND on the updated B.
- DATA_W=8, A=200, B=100, ADD -> reg_b=44, carry=1. Then SUB with A=3, B=5 -> reg_b=254, carry=1.
- Program ending in EQUAL with A=B=6 -> done=1, equal=1, invalid_op=0. PC frozen, no further mem strobes for 20 cycles.
- Opcode 0000 at PC=17 -> done=1, invalid_op=1, equal=0. A, B and memory unchanged.
- Reset asserted during the EXECUTE of a STORE -> mem_wr_en drops in the same cycle, all outputs 0, FSM in IDLE. A new start re-runs from PC=0.
